// File: rtl/yuyin_pkg.sv
// Shared types and frame constants for the voice prompt arbiter.
// State encoding, play-frame bytes and the frame byte selector.
package yuyin_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        HOLD
    } state_t;

    localparam logic [7:0] HDR      = 8'h7E;
    localparam logic [7:0] LEN      = 8'h04;
    localparam logic [7:0] CMD_PLAY = 8'h03;
    localparam logic [7:0] END      = 8'hEF;
    localparam int         FRAME_BYTES = 6;

    // Byte k of the play frame for track tt: 7E 04 03 TT CK EF.
    function automatic logic [7:0] frame_byte(
        input logic [2:0] k,
        input logic [7:0] tt
    );
        logic [7:0] b;
        unique case (k)
            3'd0:    b = HDR;
            3'd1:    b = LEN;
            3'd2:    b = CMD_PLAY;
            3'd3:    b = tt;
            3'd4:    b = LEN ^ CMD_PLAY ^ tt;
            default: b = END;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/yuyin_prompt_arbiter_if.sv
// Request/grant/serial bundle between alert sources and the arbiter.
// master drives requests and player status; slave is the arbiter.
interface yuyin_prompt_arbiter_if #(
    parameter int NREQ = 6
);
    logic            enable;
    logic [NREQ-1:0] req;
    logic            player_busy;
    logic            uart_tx;
    logic [NREQ-1:0] grant;
    logic            busy;
    logic [NREQ-1:0] lost;

    modport master (
        output enable, req, player_busy,
        input  uart_tx, grant, busy, lost
    );

    modport slave (
        input  enable, req, player_busy,
        output uart_tx, grant, busy, lost
    );
endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter, LSB first, idle high.
// done marks the last cycle of the stop bit so a new start can follow gaplessly.
module uart_tx_byte #(
    parameter int BIT_CYC = 2500
) (
    input  logic       clk_24m,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       done,
    output logic       tx
);
    localparam int CW = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYC - 1);

    logic          active;
    logic [CW-1:0] cyc;
    logic [3:0]    bitn;
    logic [8:0]    sh;

    assign done = active && (cyc == CYC_LAST) && (bitn == 4'd9);

    // Shift out start, eight data bits and stop, BIT_CYC cycles each.
    always_ff @(posedge clk_24m or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            cyc    <= '0;
            bitn   <= '0;
            sh     <= '1;
            tx     <= 1'b1;
        end else if (start) begin
            active <= 1'b1;
            cyc    <= '0;
            bitn   <= '0;
            sh     <= {1'b1, data};
            tx     <= 1'b0;
        end else if (active) begin
            if (cyc != CYC_LAST) begin
                cyc <= cyc + 1'b1;
            end else begin
                cyc <= '0;
                if (bitn == 4'd9) begin
                    active <= 1'b0;
                end else begin
                    tx   <= sh[0];
                    sh   <= {1'b1, sh[8:1]};
                    bitn <= bitn + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/yuyin_prompt_arbiter.sv
// Fixed-priority arbiter sharing the voice-player UART between alert sources.
// Optional PROMPT_PREEMPT_EN: a higher-priority request cuts the post-frame hold short.
module yuyin_prompt_arbiter
    import yuyin_pkg::*;
#(
    parameter int         NREQ       = 6,
    parameter int         CLK_HZ     = 24_000_000,
    parameter int         BAUD       = 9600,
    parameter int         HOLD_CYC   = 72_000_000,
    parameter logic [7:0] TRACK_BASE = 8'h01
) (
    input logic                   clk_24m,
    input logic                   rst_n,
    yuyin_prompt_arbiter_if.slave bus
);
    localparam int BIT_CYC = CLK_HZ / BAUD;
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYC - 1);
    localparam logic [2:0]      LAST_BYTE = 3'(FRAME_BYTES - 1);
    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    logic [NREQ-1:0] req_s1, req_s2, req_s3;
    logic            pb_s1, pb_s2;
    logic [NREQ-1:0] rise;
    logic [NREQ-1:0] pending;
    logic [NREQ-1:0] clr;
    logic [NREQ-1:0] lost;
    logic [NREQ-1:0] grant;
    logic            busy;
    state_t          state;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   pick_idx;
    logic            pick_ok;
    logic            load_go;
    logic [2:0]      byte_cnt;
    logic [HW-1:0]   hold_cnt;
    logic [7:0]      tt;
    logic            tx_start;
    logic [7:0]      tx_data;
    logic            tx_done;
    logic            tx;

    assign rise = req_s2 & ~req_s3;
    assign tt   = TRACK_BASE + 8'(idx);

    // Bring async request and BUSY pins into the clock domain.
    always_ff @(posedge clk_24m or negedge rst_n) begin
        if (!rst_n) begin
            req_s1 <= '0;
            req_s2 <= '0;
            req_s3 <= '0;
            pb_s1  <= 1'b0;
            pb_s2  <= 1'b0;
        end else begin
            req_s1 <= bus.req;
            req_s2 <= req_s1;
            req_s3 <= req_s2;
            pb_s1  <= bus.player_busy;
            pb_s2  <= pb_s1;
        end
    end

    // Lowest pending index wins.
    always_comb begin
        pick_idx = '0;
        pick_ok  = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (pending[i]) begin
                pick_idx = IW'(i);
                pick_ok  = 1'b1;
            end
        end
    end

    // Decide when a new grant is taken this cycle.
    always_comb begin
        load_go = 1'b0;
        unique case (state)
            IDLE: load_go = bus.enable & pick_ok;
            HOLD: begin
`ifdef PROMPT_PREEMPT_EN
                load_go = bus.enable & pick_ok & (pick_idx < idx);
`else
                load_go = 1'b0;
`endif
            end
            default: load_go = 1'b0;
        endcase
    end

    assign clr = load_go ? (ONE << pick_idx) : '0;

    // Latch request edges; new edges beat a same-cycle clear.
    always_ff @(posedge clk_24m or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            lost    <= '0;
        end else begin
            if (!bus.enable) begin
                pending <= '0;
            end else begin
                pending <= (pending & ~clr) | rise;
                lost    <= lost | (rise & pending);
            end
        end
    end

    // Feed the next frame byte into the transmitter with no gap.
    always_comb begin
        tx_start = 1'b0;
        tx_data  = frame_byte(3'd0, tt);
        if (state == LOAD) begin
            tx_start = 1'b1;
        end else if (state == SEND && tx_done && byte_cnt != LAST_BYTE) begin
            tx_start = 1'b1;
            tx_data  = frame_byte(byte_cnt + 3'd1, tt);
        end
    end

    // Arbitration sequence: grant, send frame, hold off for playback.
    always_ff @(posedge clk_24m or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            grant    <= '0;
            busy     <= 1'b0;
            byte_cnt <= '0;
            hold_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (load_go) begin
                        state <= LOAD;
                        idx   <= pick_idx;
                        grant <= ONE << pick_idx;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    state    <= SEND;
                    byte_cnt <= '0;
                end
                SEND: begin
                    if (tx_done) begin
                        if (byte_cnt == LAST_BYTE) begin
                            state    <= HOLD;
                            hold_cnt <= '0;
                        end else begin
                            byte_cnt <= byte_cnt + 3'd1;
                        end
                    end
                end
                HOLD: begin
                    if (!bus.enable) begin
                        state <= IDLE;
                        grant <= '0;
                        busy  <= 1'b0;
                    end else if (load_go) begin
                        state <= LOAD;
                        idx   <= pick_idx;
                        grant <= ONE << pick_idx;
                    end else if (hold_cnt != HOLD_LAST) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end else if (!pb_s2) begin
                        state <= IDLE;
                        grant <= '0;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    uart_tx_byte #(
        .BIT_CYC (BIT_CYC)
    ) u_tx (
        .clk_24m (clk_24m),
        .rst_n   (rst_n),
        .start   (tx_start),
        .data    (tx_data),
        .done    (tx_done),
        .tx      (tx)
    );

    assign bus.uart_tx = tx;
    assign bus.grant   = grant;
    assign bus.busy    = busy;
    assign bus.lost    = lost;

endmodule
